// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch sequencer: PC-addressed memory read into a handshaked instruction register
// Issues one read per instruction and pulses pc_en only when decode consumes the held word.
module instr_fetch #(
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 16,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              flush,
   input  logic [ADDR_W-1:0] pc,
   output logic              pc_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] ir,
   output logic [ADDR_W-1:0] ir_pc,
   output logic              ir_valid,
   input  logic              ir_ready
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD
   } state_t;

   localparam logic [2:0] LAST_WAIT = 3'(MEM_LAT - 1);

   state_t            r_state;
   state_t            w_next;
   logic [2:0]        r_cnt;
   logic [DATA_W-1:0] r_ir;
   logic [ADDR_W-1:0] r_ir_pc;
   logic              w_capture;
   logic              w_handshake;
   logic              w_flush;

   always_comb begin
      w_next      = r_state;
      w_capture   = 1'b0;
      w_handshake = 1'b0;
      w_flush     = flush && (r_state != S_IDLE);
      case (r_state)
         S_IDLE: if (run) w_next = S_REQ;
         S_REQ:  w_next = S_WAIT;
         S_WAIT: begin
            if (r_cnt == LAST_WAIT) begin
               w_capture = 1'b1;
               w_next    = S_HOLD;
            end
         end
         S_HOLD: begin
            if (ir_ready) begin
               w_handshake = 1'b1;
               w_next      = run ? S_REQ : S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
      // Flush beats both the capture and the handshake, so neither ir nor the PC moves.
      if (w_flush) begin
         w_next      = S_REQ;
         w_capture   = 1'b0;
         w_handshake = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 3'd0;
         r_ir    <= '0;
         r_ir_pc <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_REQ) begin
            r_ir_pc <= pc;
            r_cnt   <= 3'd0;
         end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt + 3'd1;
         end
         if (w_capture) r_ir <= mem_rdata;
      end
   end

   assign pc_en     = w_handshake;
   assign mem_addr  = pc;
   assign mem_rd_en = (r_state == S_REQ);
   assign ir_valid  = (r_state == S_HOLD);
   assign ir        = r_ir;
   assign ir_pc     = r_ir_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - bench for instr_fetch: two lanes (MEM_LAT 1 and 3) against a fetch-timing model
// Each lane has its own PC counter and latency-accurate memory that returns garbage when not read.
module tb_instr_fetch;

   localparam int AW = 10;
   localparam int DW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          run_s   [2];
   logic          flush_s [2];
   logic          ready_s [2];
   logic [AW-1:0] pc_s    [2];
   logic [AW-1:0] maddr_s [2];
   logic [AW-1:0] irpc_s  [2];
   logic          pcen_s  [2];
   logic          rden_s  [2];
   logic          valid_s [2];
   logic [DW-1:0] rdata_s [2];
   logic [DW-1:0] ir_s    [2];
   logic [DW-1:0] mem     [1024];

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;

   generate
      for (genvar g = 0; g < 2; g++) begin : lane
         localparam int LAT = (g == 0) ? 1 : 3;
         logic [AW-1:0] pc_r;
         logic [DW-1:0] pipe [LAT];

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) pc_r <= '0;
            else if (pcen_s[g]) pc_r <= pc_r + 10'd1;
         end
         assign pc_s[g] = pc_r;

         always_ff @(posedge clk) begin
            pipe[0] <= rden_s[g] ? mem[maddr_s[g]] : ~mem[maddr_s[g]];
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
         end
         assign rdata_s[g] = pipe[LAT-1];

         instr_fetch #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
            .clk       (clk),
            .rst       (rst),
            .run       (run_s[g]),
            .flush     (flush_s[g]),
            .pc        (pc_s[g]),
            .pc_en     (pcen_s[g]),
            .mem_addr  (maddr_s[g]),
            .mem_rd_en (rden_s[g]),
            .mem_rdata (rdata_s[g]),
            .ir        (ir_s[g]),
            .ir_pc     (irpc_s[g]),
            .ir_valid  (valid_s[g]),
            .ir_ready  (ready_s[g])
         );
      end
   endgenerate

   // Model: a read issued at cycle t delivers mem[addr] as a valid word at t+LAT+1 unless flushed.
   bit            pend_v    [2];
   int            pend_due  [2];
   logic [AW-1:0] pend_addr [2];
   bit            hold_v    [2];
   logic [DW-1:0] hold_ir   [2];
   logic [AW-1:0] hold_pc   [2];
   bit            req_chk   [2];
   bit            exp_req   [2];
   int            hs_cyc_q[$];
   logic [DW-1:0] hs_ir_q[$];
   logic [AW-1:0] hs_pc_q[$];

   function automatic int lat(input int l);
      return (l == 0) ? 1 : 3;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      bit due, cur_req, cur_valid, active, hs;
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
         if (!rst) begin
            pend_v[l]  = 1'b0;
            hold_v[l]  = 1'b0;
            req_chk[l] = 1'b0;
            chk($sformatf("rst_valid%0d", l), valid_s[l], 0);
            chk($sformatf("rst_rden%0d", l), rden_s[l], 0);
         end else begin
            due     = pend_v[l] && (pend_due[l] == cyc);
            cur_req = req_chk[l] && exp_req[l];
            if (due) begin
               hold_ir[l] = mem[pend_addr[l]];
               hold_pc[l] = pend_addr[l];
               pend_v[l]  = 1'b0;
            end
            cur_valid = due || hold_v[l];
            active    = cur_req || pend_v[l] || cur_valid;
            hs        = cur_valid && ready_s[l] && !flush_s[l];
            chk($sformatf("mem_addr%0d", l), maddr_s[l], pc_s[l]);
            chk($sformatf("mem_rd_en%0d", l), rden_s[l], cur_req);
            chk($sformatf("ir_valid%0d", l), valid_s[l], cur_valid);
            chk($sformatf("pc_en%0d", l), pcen_s[l], hs);
            if (cur_valid) begin
               chk($sformatf("ir%0d", l), ir_s[l], hold_ir[l]);
               chk($sformatf("ir_pc%0d", l), irpc_s[l], hold_pc[l]);
            end
            if (l == 0 && pcen_s[0]) begin
               hs_cyc_q.push_back(cyc);
               hs_ir_q.push_back(ir_s[0]);
               hs_pc_q.push_back(irpc_s[0]);
            end
            if (flush_s[l] && active) begin
               pend_v[l] = 1'b0;
            end else if (cur_req) begin
               pend_v[l]    = 1'b1;
               pend_due[l]  = cyc + lat(l) + 1;
               pend_addr[l] = pc_s[l];
            end
            hold_v[l]  = cur_valid && !ready_s[l] && !flush_s[l];
            exp_req[l] = active ? (flush_s[l] || (hs && run_s[l])) : run_s[l];
            req_chk[l] = 1'b1;
         end
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic wait_valid(input int l);
      int n = 0;
      while (!valid_s[l] && n < 20) begin
         tick();
         n++;
      end
      chk($sformatf("wait_valid%0d", l), valid_s[l], 1);
   endtask

   initial begin
      logic [AW-1:0] p;
      logic [DW-1:0] w;
      for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
      for (int i = 0; i < 4; i++) mem[i] = 16'hA000 + 16'(i);
      rst = 1'b0;
      for (int l = 0; l < 2; l++) begin
         run_s[l] = 1'b0; flush_s[l] = 1'b0; ready_s[l] = 1'b0;
      end

      // Reset and idle with run low
      repeat (3) tick();
      rst = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         for (int l = 0; l < 2; l++) begin
            chk("idle_rd_en", rden_s[l], 0);
            chk("idle_pc_en", pcen_s[l], 0);
            chk("idle_ir", ir_s[l], 0);
            chk("idle_ir_pc", irpc_s[l], 0);
         end
      end

      // Streaming on MEM_LAT=1, run dropped during the fourth fetch
      hs_cyc_q.delete(); hs_ir_q.delete(); hs_pc_q.delete();
      run_s[0] = 1'b1; ready_s[0] = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (hs_cyc_q.size() >= 3) run_s[0] = 1'b0;
      end
      chk("stream_count", hs_cyc_q.size(), 4);
      for (int i = 0; i < 4 && i < hs_cyc_q.size(); i++) begin
         chk("stream_ir", hs_ir_q[i], 32'hA000 + i);
         chk("stream_ir_pc", hs_pc_q[i], i);
         if (i > 0) chk("stream_interval", hs_cyc_q[i] - hs_cyc_q[i-1], 3);
      end
      chk("stream_pc", pc_s[0], 4);
      ready_s[0] = 1'b0;

      // Backpressure in HOLD
      run_s[0] = 1'b1;
      wait_valid(0);
      run_s[0] = 1'b0;
      w = ir_s[0];
      chk("bp_word", w, mem[4]);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("bp_valid", valid_s[0], 1);
         chk("bp_ir", ir_s[0], w);
         chk("bp_pc_en", pcen_s[0], 0);
         chk("bp_pc", pc_s[0], 4);
      end
      ready_s[0] = 1'b1;
      #1 chk("bp_release_pc_en", pcen_s[0], 1);
      tick();
      ready_s[0] = 1'b0;
      chk("bp_pc_after", pc_s[0], 5);

      // Flush during the second WAIT cycle, MEM_LAT=3
      run_s[1] = 1'b1;
      for (int n = 0; n < 10 && !rden_s[1]; n++) tick();
      chk("fw_req", rden_s[1], 1);
      run_s[1] = 1'b0;
      p = pc_s[1];
      tick();
      tick();
      flush_s[1] = 1'b1;
      tick();
      flush_s[1] = 1'b0;
      chk("fw_refetch", rden_s[1], 1);
      chk("fw_addr", maddr_s[1], p);
      wait_valid(1);
      chk("fw_ir", ir_s[1], mem[p]);
      chk("fw_pc_unmoved", pc_s[1], p);
      ready_s[1] = 1'b1;
      tick();
      ready_s[1] = 1'b0;
      chk("fw_pc_after", pc_s[1], p + 10'd1);

      // Flush together with ready in HOLD
      run_s[0] = 1'b1;
      wait_valid(0);
      p = pc_s[0];
      ready_s[0] = 1'b1; flush_s[0] = 1'b1;
      #1 chk("fr_pc_en", pcen_s[0], 0);
      tick();
      flush_s[0] = 1'b0; ready_s[0] = 1'b0; run_s[0] = 1'b0;
      chk("fr_valid", valid_s[0], 0);
      chk("fr_refetch", rden_s[0], 1);
      chk("fr_addr", maddr_s[0], p);
      wait_valid(0);
      chk("fr_ir", ir_s[0], mem[p]);
      ready_s[0] = 1'b1;
      tick();
      ready_s[0] = 1'b0;

      // Asynchronous reset between edges, with flush held to show reset wins
      run_s[0] = 1'b1; run_s[1] = 1'b1;
      wait_valid(0);
      chk("ar_lane1_wait", rden_s[1] | valid_s[1], 0);
      ready_s[0] = 1'b1;
      #1 chk("ar_pre_pc_en", pcen_s[0], 1);
      rst = 1'b0; flush_s[0] = 1'b1; flush_s[1] = 1'b1;
      #1;
      for (int l = 0; l < 2; l++) begin
         chk("ar_valid", valid_s[l], 0);
         chk("ar_rd_en", rden_s[l], 0);
         chk("ar_pc_en", pcen_s[l], 0);
         chk("ar_ir", ir_s[l], 0);
         chk("ar_ir_pc", irpc_s[l], 0);
      end
      tick();
      tick();
      rst = 1'b1; flush_s[0] = 1'b0; flush_s[1] = 1'b0; ready_s[0] = 1'b0;
      tick();
      for (int l = 0; l < 2; l++) begin
         chk("ar_restart_req", rden_s[l], 1);
         chk("ar_restart_addr", maddr_s[l], 0);
      end

      // Randomized traffic on both lanes
      for (int k = 0; k < 600; k++) begin
         for (int l = 0; l < 2; l++) begin
            run_s[l]   = ($urandom_range(0, 3) != 0);
            ready_s[l] = 1'($urandom_range(0, 1));
            flush_s[l] = ($urandom_range(0, 9) == 0);
         end
         tick();
      end
      for (int l = 0; l < 2; l++) begin
         run_s[l] = 1'b0; flush_s[l] = 1'b0; ready_s[l] = 1'b1;
      end
      repeat (10) tick();
      for (int l = 0; l < 2; l++) chk("drain_idle", valid_s[l] | rden_s[l], 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
